// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg
//   Shared types and decode function for the RV32I decode stage.
//   - op_class_e   : decoded operation class carried with each entry
//   - dec_entry_t  : one decoded entry {op_class, rd, rs1, rs2, imm, pc}
//   - skid_state_e : occupancy of the 2-entry skid buffer
//   - decode_instr : purely combinational decode of one raw word (pc left 0)
package rv_decode_pkg;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      OP_ILLEGAL = 3'd0,
      OP_ADDI    = 3'd1,
      OP_ADD     = 3'd2,
      OP_BEQ     = 3'd3,
      OP_JAL     = 3'd4
   } op_class_e;

   typedef struct packed {
      op_class_e             op_class;
      logic [REG_W-1:0]      rd;
      logic [REG_W-1:0]      rs1;
      logic [REG_W-1:0]      rs2;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       pc;
   } dec_entry_t;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_e;

   // Unrecognised words keep their raw register fields and a zero immediate.
   // Fields that the recognised formats do not define (rd of BEQ, rs1/rs2
   // of JAL) are forced to 0 so downstream never sees stray indices.
   function automatic dec_entry_t decode_instr(input logic [XLEN-1:0] word);
      dec_entry_t e;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc        = word[6:0];
      f3         = word[14:12];
      f7         = word[31:25];
      e          = '0;
      e.op_class = OP_ILLEGAL;
      e.rd       = word[11:7];
      e.rs1      = word[19:15];
      e.rs2      = word[24:20];
      e.imm      = '0;
      case (opc)
         OPC_OP_IMM: begin
            if (f3 == 3'b000) begin
               e.op_class = OP_ADDI;
               e.imm      = {{20{word[31]}}, word[31:20]};
            end
         end
         OPC_OP: begin
            if (f3 == 3'b000 && f7 == 7'b0000000) begin
               e.op_class = OP_ADD;
            end
         end
         OPC_BRANCH: begin
            if (f3 == 3'b000) begin
               e.op_class = OP_BEQ;
               e.rd       = '0;
               e.imm      = {{19{word[31]}}, word[31], word[7],
                             word[30:25], word[11:8], 1'b0};
            end
         end
         OPC_JAL: begin
            e.op_class = OP_JAL;
            e.rs1      = '0;
            e.rs2      = '0;
            e.imm      = {{11{word[31]}}, word[31], word[19:12],
                          word[20], word[30:21], 1'b0};
         end
         default: ;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/rv_decode_skid.sv
// rv_decode_skid
//   2-entry skid buffer over dec_entry_t giving one entry per cycle with a
//   registered in_ready (depends on occupancy only, never on out_ready).
//   Ports:
//     clk, arst           clock / asynchronous active-high reset
//     flush               synchronous discard of both entries
//     in_valid/in_ready   upstream handshake, in_data entry
//     out_valid/out_ready downstream handshake, out_data entry
module rv_decode_skid
   import rv_decode_pkg::*;
(
   input  logic       clk,
   input  logic       arst,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  dec_entry_t in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output dec_entry_t out_data
);

   skid_state_e state_reg;
   logic        out_valid_reg;
   dec_entry_t  data_reg;
   dec_entry_t  skid_reg;
   logic        accept;
   logic        consume;

   // Forced low during reset so nothing is taken while state is being cleared.
   assign in_ready = !arst && (state_reg != SKID_TWO);
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid_reg && out_ready;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_reg     <= SKID_EMPTY;
         out_valid_reg <= 1'b0;
         data_reg      <= '0;
         skid_reg      <= '0;
      end else if (flush) begin
         state_reg     <= SKID_EMPTY;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            SKID_EMPTY: begin
               if (accept) begin
                  data_reg      <= in_data;
                  out_valid_reg <= 1'b1;
                  state_reg     <= SKID_ONE;
               end
            end
            SKID_ONE: begin
               if (accept && consume) begin
                  data_reg <= in_data;
               end else if (accept) begin
                  // Output is stalled: park the new word behind it.
                  skid_reg  <= in_data;
                  state_reg <= SKID_TWO;
               end else if (consume) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= SKID_EMPTY;
               end
            end
            SKID_TWO: begin
               if (consume) begin
                  data_reg  <= skid_reg;
                  state_reg <= SKID_ONE;
               end
            end
            default: begin
               state_reg     <= SKID_EMPTY;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = data_reg;

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage
//   Registered RV32I decode stage (ADDI, ADD, BEQ, JAL; all else illegal).
//   Raw words are decoded combinationally and the result is registered
//   through a 2-entry skid buffer, giving 1-cycle latency and full rate.
//   Ports:
//     clk, arst                 clock / asynchronous active-high reset
//     flush                     synchronous discard of buffered entries
//     in_valid, in_ready        input handshake; instruction, pc_in word
//     out_valid, out_ready      output handshake
//     op_class, rd, rs1, rs2    decoded fields
//     imm, pc_out               sign-extended immediate, entry PC
//     illegal_cnt               saturating count of accepted illegal words
module rv_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int DATA_WIDTH    = XLEN,
   parameter int DIR_WIDTH     = REG_W,
   parameter int ILL_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    instruction,
   input  logic [DATA_WIDTH-1:0]    pc_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               op_class,
   output logic [DIR_WIDTH-1:0]     rd,
   output logic [DIR_WIDTH-1:0]     rs1,
   output logic [DIR_WIDTH-1:0]     rs2,
   output logic [DATA_WIDTH-1:0]    imm,
   output logic [DATA_WIDTH-1:0]    pc_out,
   output logic [ILL_CNT_WIDTH-1:0] illegal_cnt
);

   dec_entry_t               dec_in;
   dec_entry_t               dec_out;
   logic                     accept;
   logic [ILL_CNT_WIDTH-1:0] illegal_cnt_reg;

   always_comb begin
      dec_in    = decode_instr(instruction);
      dec_in.pc = pc_in;
   end

   rv_decode_skid u_skid (
      .clk       (clk),
      .arst      (arst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (dec_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (dec_out)
   );

   // A word offered alongside flush is dropped by the buffer, so it must
   // not be counted either.
   assign accept = in_valid && in_ready && !flush;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         illegal_cnt_reg <= '0;
      end else if (accept && dec_in.op_class == OP_ILLEGAL
                   && illegal_cnt_reg != {ILL_CNT_WIDTH{1'b1}}) begin
         illegal_cnt_reg <= illegal_cnt_reg + ILL_CNT_WIDTH'(1);
      end
   end

   assign op_class    = dec_out.op_class;
   assign rd          = dec_out.rd;
   assign rs1         = dec_out.rs1;
   assign rs2         = dec_out.rs2;
   assign imm         = dec_out.imm;
   assign pc_out      = dec_out.pc;
   assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage
//   Directed bench for rv_decode_stage with hand-computed expected decodes.
//   The illegal counter is built 4 bits wide so saturation is reachable.
module tb_rv_decode_stage;

   localparam int ILL_W   = 4;
   localparam int ILL_MAX = (1 << ILL_W) - 1;

   localparam logic [31:0] W_ADDI  = 32'hFFF18293;  // addi x5,x3,-1
   localparam logic [31:0] W_ADD   = 32'h003100B3;  // add x1,x2,x3
   localparam logic [31:0] W_BEQ   = 32'h00208463;  // beq x1,x2,+8
   localparam logic [31:0] W_JAL   = 32'hFFDFF0EF;  // jal x1,-4
   localparam logic [31:0] W_ZERO  = 32'h00000000;
   localparam logic [31:0] W_SUB   = 32'h403100B3;  // sub: not supported

   logic             clk;
   logic             arst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instruction;
   logic [31:0]      pc_in;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       op_class;
   logic [4:0]       rd;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [31:0]      imm;
   logic [31:0]      pc_out;
   logic [ILL_W-1:0] illegal_cnt;

   int checks;
   int failures;

   rv_decode_stage #(
      .DATA_WIDTH    (32),
      .DIR_WIDTH     (5),
      .ILL_CNT_WIDTH (ILL_W)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .pc_in       (pc_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .op_class    (op_class),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .imm         (imm),
      .pc_out      (pc_out),
      .illegal_cnt (illegal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc);
      in_valid    = v;
      instruction = w;
      pc_in       = pc;
   endtask

   task automatic expect_entry(input string tag, input logic [2:0] cls,
                               input logic [4:0] e_rd, input logic [4:0] e_rs1,
                               input logic [4:0] e_rs2, input logic [31:0] e_imm,
                               input logic [31:0] e_pc);
      $display("txn %s: valid=%0b cls=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%08h pc=0x%08h",
               tag, out_valid, op_class, rd, rs1, rs2, imm, pc_out);
      check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, ".cls"},   {29'b0, op_class},  {29'b0, cls});
      check({tag, ".rd"},    {27'b0, rd},        {27'b0, e_rd});
      check({tag, ".rs1"},   {27'b0, rs1},       {27'b0, e_rs1});
      check({tag, ".rs2"},   {27'b0, rs2},       {27'b0, e_rs2});
      check({tag, ".imm"},   imm,                e_imm);
      check({tag, ".pc"},    pc_out,             e_pc);
   endtask

   task automatic expect_cnt(input string tag, input int exp);
      check(tag, {{(32-ILL_W){1'b0}}, illegal_cnt}, 32'(exp));
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      arst      = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);

      // ---------------- reset state ----------------
      #12;
      check("rst.out_valid", {31'b0, out_valid}, 32'd0);
      check("rst.in_ready",  {31'b0, in_ready},  32'd0);
      check("rst.imm",       imm,                32'd0);
      check("rst.pc_out",    pc_out,             32'd0);
      expect_cnt("rst.cnt", 0);
      #4 arst = 1'b0;   // released between edges
      step();
      check("idle.in_ready", {31'b0, in_ready}, 32'd1);

      // ---------------- single ADDI ----------------
      drive(1'b1, W_ADDI, 32'h100);
      step();
      drive(1'b0, 32'h0, 32'h0);
      expect_entry("addi", 3'd1, 5'd5, 5'd3, 5'd31, 32'hFFFFFFFF, 32'h100);
      out_ready = 1'b1;
      step();
      check("addi.drain", {31'b0, out_valid}, 32'd0);

      // ---------------- back-to-back at full rate ----------------
      drive(1'b1, W_ADD, 32'h104);
      step();
      expect_entry("b2b.add", 3'd2, 5'd1, 5'd2, 5'd3, 32'h0, 32'h104);
      drive(1'b1, W_BEQ, 32'h108);
      step();
      expect_entry("b2b.beq", 3'd3, 5'd0, 5'd1, 5'd2, 32'h8, 32'h108);
      drive(1'b1, W_JAL, 32'h10C);
      step();
      expect_entry("b2b.jal", 3'd4, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h10C);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check("b2b.empty", {31'b0, out_valid}, 32'd0);

      // ---------------- backpressure ----------------
      out_ready = 1'b0;
      drive(1'b1, W_ADDI, 32'h200);
      step();
      check("bp.ready1", {31'b0, in_ready}, 32'd1);
      drive(1'b1, W_ADD, 32'h204);
      step();
      check("bp.ready2", {31'b0, in_ready}, 32'd0);
      drive(1'b1, W_BEQ, 32'h208);   // held by source until accepted
      step();
      expect_entry("bp.hold", 3'd1, 5'd5, 5'd3, 5'd31, 32'hFFFFFFFF, 32'h200);
      check("bp.blocked", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      step();
      expect_entry("bp.w2", 3'd2, 5'd1, 5'd2, 5'd3, 32'h0, 32'h204);
      check("bp.reopen", {31'b0, in_ready}, 32'd1);
      step();
      drive(1'b0, 32'h0, 32'h0);
      expect_entry("bp.w3", 3'd3, 5'd0, 5'd1, 5'd2, 32'h8, 32'h208);
      step();
      check("bp.empty", {31'b0, out_valid}, 32'd0);

      // ---------------- illegal words ----------------
      drive(1'b1, W_ZERO, 32'h300);
      step();
      expect_entry("ill.zero", 3'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h300);
      expect_cnt("ill.cnt1", 1);
      drive(1'b1, W_SUB, 32'h304);
      step();
      drive(1'b0, 32'h0, 32'h0);
      expect_entry("ill.sub", 3'd0, 5'd1, 5'd2, 5'd3, 32'h0, 32'h304);
      expect_cnt("ill.cnt2", 2);
      step();

      // ---------------- flush ----------------
      out_ready = 1'b0;
      drive(1'b1, W_ADDI, 32'h400);
      step();
      drive(1'b1, W_ADD, 32'h404);
      step();
      check("fl.two", {31'b0, in_ready}, 32'd0);
      drive(1'b1, W_ZERO, 32'h408);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("fl.two.valid", {31'b0, out_valid}, 32'd0);
      check("fl.two.ready", {31'b0, in_ready},  32'd1);
      expect_cnt("fl.two.cnt", 2);
      // Flush in EMPTY while the stage is ready: the illegal word is dropped.
      drive(1'b1, W_ZERO, 32'h40C);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("fl.empty.valid", {31'b0, out_valid}, 32'd0);
      expect_cnt("fl.empty.cnt", 2);
      // Stage still works after flush.
      out_ready = 1'b1;
      drive(1'b1, W_JAL, 32'h410);
      step();
      drive(1'b0, 32'h0, 32'h0);
      expect_entry("fl.after", 3'd4, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h410);
      step();

      // ---------------- counter saturation ----------------
      for (int i = 0; i < ILL_MAX - 3; i++) begin
         drive(1'b1, W_ZERO, 32'h500 + 32'(i));
         step();
      end
      drive(1'b0, 32'h0, 32'h0);
      expect_cnt("sat.below", ILL_MAX - 1);
      drive(1'b1, W_SUB, 32'h600);
      step();
      expect_cnt("sat.max", ILL_MAX);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, W_ZERO, 32'h604 + 32'(i));
         step();
      end
      drive(1'b0, 32'h0, 32'h0);
      expect_cnt("sat.hold", ILL_MAX);
      step();

      // ---------------- asynchronous reset while in TWO ----------------
      out_ready = 1'b0;
      drive(1'b1, W_BEQ, 32'h700);
      step();
      drive(1'b1, W_JAL, 32'h704);
      step();
      drive(1'b0, 32'h0, 32'h0);
      check("ar.two", {31'b0, in_ready}, 32'd0);
      #2 arst = 1'b1;
      #1;
      check("ar.valid", {31'b0, out_valid}, 32'd0);
      check("ar.ready", {31'b0, in_ready},  32'd0);
      check("ar.cls",   {29'b0, op_class},  32'd0);
      check("ar.imm",   imm,                32'd0);
      check("ar.pc",    pc_out,             32'd0);
      expect_cnt("ar.cnt", 0);
      #1 arst = 1'b0;
      step();
      check("ar.idle", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b1;
      drive(1'b1, W_ADDI, 32'h800);
      step();
      drive(1'b0, 32'h0, 32'h0);
      expect_entry("ar.fresh", 3'd1, 5'd5, 5'd3, 5'd31, 32'hFFFFFFFF, 32'h800);
      step();
      check("ar.nostale", {31'b0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RV32I decode stage: the receiving end of the instruction-encoding interface that the bench drives into the core.
- Accepts raw 32-bit instruction words with a valid/ready handshake.
- Decodes ADDI, ADD, BEQ and JAL into register indices, an op class and a sign-extended immediate. Everything else is flagged illegal.
- Sits between the instruction source and control_unit/prf. A 2-entry skid buffer gives full throughput under backpressure.

Parameters:
- DATA_WIDTH, 32, instruction/immediate/PC width.
- DIR_WIDTH, 5, register index width.
- ILL_CNT_WIDTH, 16, width of saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage can accept.
- instruction  in  DATA_WIDTH  raw RV32I word.
- pc_in  in  DATA_WIDTH  PC of the word.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  consumer accepts.
- op_class  out  3  op_class_e (see Decomposition).
- rd, rs1, rs2  out  DIR_WIDTH each  register fields.
- imm  out  DATA_WIDTH  sign-extended immediate (0 for ADD/ILLEGAL).
- pc_out  out  DATA_WIDTH  PC of the entry.
- illegal_cnt  out  ILL_CNT_WIDTH  count of illegal words accepted.

Behaviour:
Reset:
- arst=1 asynchronously clears out_valid, op_class, rd, rs1, rs2, imm, pc_out and illegal_cnt to 0.
- State goes to EMPTY; in_ready=0 while arst=1.
- Reset mid-transfer drops all held entries.

Handshake and latency:
- Transfer occurs when valid&ready are both high at a rising edge.
- Latency is 1 cycle: a word accepted at edge N appears on outputs after edge N.
- Outputs stay stable while out_valid&!out_ready.

State machine (occupancy):
- EMPTY: out_valid=0, in_ready=1. On accept → ONE.
- ONE: out_valid=1, in_ready=1.
  - accept & consume → ONE (output replaced).
  - accept & !consume → TWO (word goes to skid).
  - consume only → EMPTY.
- TWO: out_valid=1, in_ready=0.
  - consume → ONE (skid moves to output).
- in_ready depends only on state, never combinationally on out_ready.

Decode is combinational on the input word; results are registered with the entry.
- ADDI: opcode 0010011, funct3 000. imm = sext(inst[31:20]).
- ADD: opcode 0110011, funct3 000, funct7 0000000. imm = 0.
- BEQ: opcode 1100011, funct3 000. imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}). rd = 0.
- JAL: opcode 1101111. imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). rs1 = rs2 = 0.
- Any other encoding → OP_ILLEGAL.
  - rd/rs1/rs2 are raw fields, imm = 0.
  - illegal_cnt increments on accept and saturates at all-ones.

Flush:
- Next state EMPTY; out_valid=0 on the next cycle.
- An input presented in the same cycle as flush is dropped and is not counted.
- Flush has priority over accept and consume.

Simultaneous events:
- Consume and accept in the same cycle in ONE sustain 1 word/cycle.
- Consume and a blocked input in TWO: input is not accepted that cycle.

Decomposition:
- Package rv_decode_pkg holds:
  - op_class_e: OP_ILLEGAL=0, OP_ADDI=1, OP_ADD=2, OP_BEQ=3, OP_JAL=4.
  - Opcode constants: OPC_OP_IMM, OPC_OP, OPC_BRANCH, OPC_JAL.
  - Packed struct dec_entry_t {op_class, rd, rs1, rs2, imm, pc}.
  - Function decode_instr(word) returning dec_entry_t.
- Natural sub-module: rv_decode_skid, a generic 2-entry skid buffer over dec_entry_t.

Test Plan:
- Reset, then in_valid with 0xFFF18293 (ADDI x5,x3,-1), pc 0x100 → next cycle out_valid=1, op_class=OP_ADDI, rd=5, rs1=3, imm=0xFFFFFFFF, pc_out=0x100.
- Back-to-back with out_ready=1: 0x003100B3, then 0x00208463, then 0xFFDFF0EF → one result per cycle:
  - ADD: rd=1, rs1=2, rs2=3, imm=0.
  - BEQ: rs1=1, rs2=2, imm=0x8.
  - JAL: rd=1, imm=0xFFFFFFFC.
- Backpressure: out_ready=0 and push 3 words → 2 accepted, in_ready=0 after the 2nd, outputs hold the first word. Raise out_ready → words drain in order with none lost or duplicated.
- Illegal: push 0x00000000 and 0x403100B3 (SUB) → both OP_ILLEGAL with imm=0, illegal_cnt=2. Preload the count to all-ones by forcing → it saturates.
- Flush in TWO concurrent with in_valid → next cycle out_valid=0, state EMPTY, flushed input not counted.
- Assert arst asynchronously mid-clock while in TWO → outputs 0 immediately. After release, a fresh ADDI decodes correctly.
